// File: rtl/param_stack.sv
// param_stack: parametrised LIFO register stack with full/empty/count status,
// replace-top push+pop and clear/hold-qualified pop. Define PARAM_STACK_ERR_IRQ_EN for error reporting.

module param_stack_chk #(
    parameter int PTR_W = 10,
    parameter int DEPTH = 1024
) (
    input logic             clk,
    input logic             reset,
    input logic             full,
    input logic             empty,
    input logic [PTR_W:0]   count,
    input logic             err_irq,
    input logic [1:0]       err_status
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    a_count_range: assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);
    a_full_flag:   assert property (@(posedge clk) disable iff (reset) full == (count == DEPTH_C));
    a_empty_flag:  assert property (@(posedge clk) disable iff (reset) empty == (count == {(PTR_W+1){1'b0}}));
    a_irq_sticky:  assert property (@(posedge clk) disable iff (reset) err_irq |-> (err_status != 2'b00));
endmodule

module param_stack #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic              hold,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count,
    output logic              err_irq,
    output logic [1:0]        err_status
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_C   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0] ZERO_C  = {(PTR_W+1){1'b0}};

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W:0]    ptr_q, ptr_d, ptr_m1_s;
    logic [DATA_W-1:0] q_q, q_d;
    logic              full_q, empty_q;
    logic              q_from_mem_s;
    logic              wr_en_s;
    logic [PTR_W-1:0]  wr_addr_s, rd_addr_s;
    logic              pop_eff_s, is_full_s, is_empty_s;

    assign pop_eff_s  = pop & ~clear & ~hold;
    assign is_full_s  = (ptr_q == DEPTH_C);
    assign is_empty_s = (ptr_q == ZERO_C);
    assign ptr_m1_s   = ptr_q - ONE_C;
    assign rd_addr_s  = ptr_m1_s[PTR_W-1:0];

    // Next-state decode: pointer movement, memory write and source of q.
    always_comb begin
        ptr_d        = ptr_q;
        wr_en_s      = 1'b0;
        wr_addr_s    = ptr_q[PTR_W-1:0];
        q_from_mem_s = 1'b0;
        if (pop && clear) begin
            q_d = {DATA_W{1'b0}};
        end else begin
            q_d = q_q;
        end

        if (push && pop_eff_s) begin
            // Replace top: the read returns the old top while the write lands on the same slot.
            if (!is_empty_s) begin
                q_from_mem_s = 1'b1;
                wr_en_s      = 1'b1;
                wr_addr_s    = rd_addr_s;
            end else begin
                q_d = d;
            end
        end else if (push) begin
            if (!is_full_s) begin
                wr_en_s = 1'b1;
                ptr_d   = ptr_q + ONE_C;
            end else begin
                ptr_d = ptr_q;
            end
        end else if (pop_eff_s) begin
            if (!is_empty_s) begin
                q_from_mem_s = 1'b1;
                ptr_d        = ptr_m1_s;
            end else begin
                q_d = {DATA_W{1'b0}};
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Storage array write port; contents deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_addr_s] <= d;
        end
    end

    // Registered read port and output data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= {DATA_W{1'b0}};
        end else if (q_from_mem_s) begin
            q_q <= mem_q[rd_addr_s];
        end else begin
            q_q <= q_d;
        end
    end

    // Pointer and registered status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q   <= ZERO_C;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            full_q  <= (ptr_d == DEPTH_C);
            empty_q <= (ptr_d == ZERO_C);
        end
    end

    assign q     = q_q;
    assign count = ptr_q;
    assign full  = full_q;
    assign empty = empty_q;

`ifdef PARAM_STACK_ERR_IRQ_EN
    logic       ovf_s, unf_s;
    logic       err_irq_q;
    logic [1:0] err_status_q;

    // Overflow: push-only when full (includes push alongside a cleared/held pop).
    assign ovf_s = push & ~pop_eff_s & is_full_s;
    assign unf_s = pop_eff_s & ~push & is_empty_s;

    // One-cycle error pulse plus sticky {overflow, underflow} status.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_irq_q    <= 1'b0;
            err_status_q <= 2'b00;
        end else begin
            err_irq_q    <= ovf_s | unf_s;
            err_status_q <= err_status_q | {ovf_s, unf_s};
        end
    end

    assign err_irq    = err_irq_q;
    assign err_status = err_status_q;
`else
    assign err_irq    = 1'b0;
    assign err_status = 2'b00;
`endif

    param_stack_chk #(
        .PTR_W (PTR_W),
        .DEPTH (DEPTH)
    ) u_chk (
        .clk        (clk),
        .reset      (reset),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .err_irq    (err_irq),
        .err_status (err_status)
    );
endmodule

// File: tb/tb_param_stack.sv
// Self-checking bench for param_stack (DATA_W=8, DEPTH=4): directed scenarios plus
// randomized traffic against a queue-based LIFO reference model.

module tb_param_stack;
    localparam int DW = 8;
    localparam int DP = 4;
    localparam int PW = 2;
`ifdef PARAM_STACK_ERR_IRQ_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] d, q;
    logic          push, pop, clear, hold;
    logic          full, empty;
    logic [PW:0]   count;
    logic          err_irq;
    logic [1:0]    err_status;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] stk [$];
    logic [DW-1:0] m_q;
    logic          m_irq;
    logic [1:0]    m_status;

    param_stack #(.DATA_W(DW), .DEPTH(DP)) dut (
        .clk(clk), .reset(reset), .d(d), .q(q), .push(push), .pop(pop),
        .clear(clear), .hold(hold), .full(full), .empty(empty), .count(count),
        .err_irq(err_irq), .err_status(err_status)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        stk.delete();
        m_q      = '0;
        m_irq    = 1'b0;
        m_status = 2'b00;
    endtask

    task automatic model_step(input logic pu, input logic po, input logic cl, input logic ho,
                              input logic [DW-1:0] dv);
        bit pe;
        bit ovf;
        bit unf;
        pe  = po && !cl && !ho;
        ovf = 1'b0;
        unf = 1'b0;
        if (po && cl) m_q = '0;
        if (pu && pe) begin
            if (stk.size() > 0) begin
                m_q = stk[$];
                stk[$] = dv;
            end else begin
                m_q = dv;
            end
        end else if (pu) begin
            if (stk.size() < DP) stk.push_back(dv);
            else ovf = 1'b1;
        end else if (pe) begin
            if (stk.size() > 0) m_q = stk.pop_back();
            else begin
                m_q = '0;
                unf = 1'b1;
            end
        end
        m_irq    = ovf | unf;
        m_status = m_status | {ovf, unf};
    endtask

    task automatic step(input logic pu, input logic po, input logic cl, input logic ho,
                        input logic [DW-1:0] dv);
        @(negedge clk);
        push = pu; pop = po; clear = cl; hold = ho; d = dv;
        @(posedge clk);
        #1;
        model_step(pu, po, cl, ho, dv);
        push = 1'b0; pop = 1'b0; clear = 1'b0; hold = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #2;
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h want 00", q); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL reset_flags: empty=%b full=%b want 1 0", empty, full); end
        checks++; if (err_irq !== 1'b0 || err_status !== 2'b00) begin errors++; $display("FAIL reset_err: irq=%b status=%b want 0 00", err_irq, err_status); end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_lifo();
        logic [DW-1:0] exp_q [3];
        exp_q[0] = 8'h33; exp_q[1] = 8'h22; exp_q[2] = 8'h11;
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL lifo_count3: got %0d want 3", count); end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
            checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL lifo_pop%0d: q=%h want %h", i, q, exp_q[i]); end
            checks++; if (count !== 3'(2 - i)) begin errors++; $display("FAIL lifo_cnt%0d: got %0d want %0d", i, count, 2 - i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lifo_empty: got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 8'hA0 + 8'(i));
            if (i == 3) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full4: got %b want 1", full); end
            end
        end
        checks++; if (count !== 3'd4 || full !== 1'b1) begin errors++; $display("FAIL ovf_count: count=%0d full=%b want 4 1", count, full); end
        checks++; if (err_irq !== ERR_EN) begin errors++; $display("FAIL ovf_irq: got %b want %b", err_irq, ERR_EN); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (err_irq !== 1'b0) begin errors++; $display("FAIL ovf_irq_pulse: got %b want 0", err_irq); end
        checks++; if (err_status !== (ERR_EN ? 2'b10 : 2'b00)) begin errors++; $display("FAIL ovf_status: got %b want %b", err_status, ERR_EN ? 2'b10 : 2'b00); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'hA3 || count !== 3'd3) begin errors++; $display("FAIL ovf_pop: q=%h count=%0d want a3 3", q, count); end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h00 || count !== 3'd0) begin errors++; $display("FAIL unf_q: q=%h count=%0d want 00 0", q, count); end
        checks++; if (err_irq !== ERR_EN) begin errors++; $display("FAIL unf_irq: got %b want %b", err_irq, ERR_EN); end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        checks++; if (err_irq !== 1'b0 || err_status !== (ERR_EN ? 2'b01 : 2'b00)) begin errors++; $display("FAIL unf_status: irq=%b status=%b want 0 %b", err_irq, err_status, ERR_EN ? 2'b01 : 2'b00); end
    endtask

    task automatic test_hold_clear();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h06);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h06) begin errors++; $display("FAIL hc_pop: q=%h want 06", q); end
        step(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        checks++; if (q !== 8'h06 || count !== 3'd1) begin errors++; $display("FAIL hc_hold: q=%h count=%0d want 06 1", q, count); end
        step(1'b1, 1'b1, 1'b0, 1'b1, 8'h0C);
        checks++; if (q !== 8'h06 || count !== 3'd2) begin errors++; $display("FAIL hc_push_hold: q=%h count=%0d want 06 2", q, count); end
        step(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        checks++; if (q !== 8'h00 || count !== 3'd2) begin errors++; $display("FAIL hc_clear_hold: q=%h count=%0d want 00 2", q, count); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h0C || count !== 3'd1) begin errors++; $display("FAIL hc_pop2: q=%h count=%0d want 0c 1", q, count); end
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        checks++; if (q !== 8'h00 || count !== 3'd1) begin errors++; $display("FAIL hc_clear: q=%h count=%0d want 00 1", q, count); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h05 || count !== 3'd0) begin errors++; $display("FAIL hc_final: q=%h count=%0d want 05 0", q, count); end
    endtask

    task automatic test_replace();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h09);
        checks++; if (q !== 8'h07 || count !== 3'd1) begin errors++; $display("FAIL rep_top: q=%h count=%0d want 07 1", q, count); end
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h09 || count !== 3'd0) begin errors++; $display("FAIL rep_pop: q=%h count=%0d want 09 0", q, count); end
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h03);
        checks++; if (q !== 8'h03 || count !== 3'd0) begin errors++; $display("FAIL rep_empty: q=%h count=%0d want 03 0", q, count); end
        checks++; if (err_irq !== 1'b0) begin errors++; $display("FAIL rep_noerr: irq=%b want 0", err_irq); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h41);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h42);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h43);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (count !== 3'd0 || empty !== 1'b1 || q !== 8'h00) begin errors++; $display("FAIL async_reset: count=%0d empty=%b q=%h want 0 1 00", count, empty, q); end
        #3;
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 8'h01);
        step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        checks++; if (q !== 8'h01 || count !== 3'd0) begin errors++; $display("FAIL async_after: q=%h count=%0d want 01 0", q, count); end
    endtask

    task automatic test_random();
        logic pu, po, cl, ho;
        int push_pct;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            push_pct = ((i / 40) % 2 == 0) ? 75 : 25;
            pu = ($urandom_range(0, 99) < push_pct);
            po = ($urandom_range(0, 99) < 100 - push_pct);
            cl = ($urandom_range(0, 99) < 8);
            ho = ($urandom_range(0, 99) < 10);
            step(pu, po, cl, ho, 8'($urandom));
            checks++;
            if (q !== m_q || count !== 3'(stk.size()) || full !== (stk.size() == DP) ||
                empty !== (stk.size() == 0) || err_irq !== (m_irq & ERR_EN) ||
                err_status !== (ERR_EN ? m_status : 2'b00)) begin
                errors++;
                $display("FAIL rand_%0d: q=%h cnt=%0d f=%b e=%b irq=%b st=%b want q=%h cnt=%0d irq=%b st=%b",
                         i, q, count, full, empty, err_irq, err_status, m_q, stk.size(),
                         m_irq & ERR_EN, ERR_EN ? m_status : 2'b00);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        push = 1'b0; pop = 1'b0; clear = 1'b0; hold = 1'b0; d = '0;
        model_reset();
        #12;
        reset = 1'b0;
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_hold_clear();
        test_replace();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_stack.md
Name: param_stack

Overview:
- Parametrised LIFO register stack; successor to the fixed 32x1024 CPU stack.
- Used by the CPU for register backup in assembly and for nested interrupt context save.
- Adds configurable width and depth, full/empty/count status, defined overflow/underflow handling and a same-cycle push+pop (replace-top) mode.
- Retains the pipeline clear/hold qualification on pop.

Parameters:
- DATA_W, 32, width of each entry in bits.
- DEPTH, 1024, number of entries; must be a power of two and at least 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- d  input  DATA_W  data to push.
- q  output  DATA_W  popped data, registered.
- push  input  1  push request.
- pop  input  1  pop request.
- clear  input  1  pipeline flush; qualifies pop.
- hold  input  1  pipeline stall; qualifies pop.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  PTR_W+1  number of valid entries.
- err_irq  output  1  one-cycle error pulse (optional feature).
- err_status  output  2  sticky {overflow, underflow} (optional feature).

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - ptr=0, q=0, count=0, empty=1, full=0, err_irq=0, err_status=0.
  - Memory contents are not cleared and are not guaranteed.
- Effective pop: pop_eff = pop & ~clear & ~hold.
- pop & clear: q <= 0; ptr unchanged. clear has priority over hold.
- pop & hold & ~clear: q holds its value; ptr unchanged.
- Push only (push & ~pop_eff):
  - Not full: mem[ptr] <= d, ptr <= ptr+1.
  - Full: write dropped, ptr unchanged; this is an overflow event.
- Pop only (pop_eff & ~push):
  - Not empty: q <= mem[ptr-1], ptr <= ptr-1.
  - Empty: q <= 0, ptr unchanged; this is an underflow event.
- push & pop_eff (replace top), ptr unchanged, never an error:
  - Not empty: q <= mem[ptr-1] (old top), mem[ptr-1] <= d.
  - Empty: q <= d (pass-through), no write.
- push with pop & (clear|hold): the push proceeds as push-only; the pop is handled per the clear/hold rules.
- Latency: q is valid the cycle after the pop edge and holds until the next pop.
  - push/clear/hold without pop never change q.
- full, empty and count are registered and reflect the ptr after the edge.
  - Back-to-back push and pop every cycle is supported with no bubbles.
- Arithmetic:
  - ptr is PTR_W+1 bits and equals count.
  - mem is indexed with ptr[PTR_W-1:0].
  - No wrap-around; saturation is enforced by the full/empty checks.
- Memory is inferred as a synchronous RAM:
  - one write port;
  - one read port addressed by ptr-1, with a 0 substitute when empty.

Optional Feature:
- Macro: PARAM_STACK_ERR_IRQ_EN.
- Defined:
  - err_irq pulses high for exactly one cycle after any overflow or underflow event.
  - err_status[1] (overflow) and err_status[0] (underflow) set on the event and stay set until reset.
  - The CPU routes err_irq to the interrupt controller.
- Not defined:
  - err_irq and err_status are tied to 0; no error logic is synthesised.
  - Data-path behaviour is identical either way.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles, then pop three times -> q = 0x33, 0x22, 0x11 one cycle after each pop; count goes 3, 2, 1, 0; empty=1 at the end.
- DEPTH=4: push 5 values (0xA0..0xA4) -> full=1 after the 4th; 5th dropped; count=4; pop returns 0xA3 first. With the macro: err_irq pulses once and err_status=2'b10.
- Pop on empty -> q=0, count stays 0. With the macro: err_status=2'b01 and one err_irq pulse.
- Push 0x5, then pop with hold=1 -> q unchanged, count=1. Pop with clear=1 -> q=0, count=1. Plain pop -> q=0x5, count=0.
- Push 0x7, then push 0x9 with pop in the same cycle -> q=0x7, count=1. Next pop -> q=0x9. Push+pop on empty with d=0x3 -> q=0x3, count=0.
- Assert reset asynchronously (between clock edges) after 3 pushes -> count=0, empty=1 and q=0 immediately, without waiting for an edge. A following push 0x1 then pop -> q=0x1.
